// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains 32-bit FIFO words into four 8N1 UART frames.
// Byte 0 goes first, each byte LSB first, no gaps within a chain.
module fifo_uart_tx #(
  parameter int CLK_DIV = 434
) (
  input  logic        clock,
  input  logic        sclr,
  input  logic        en,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_q,
  output logic        fifo_rdreq,
  output logic        txd,
  output logic        busy,
  output logic        tx_done
);

  localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] LAST = BW'(CLK_DIV - 1);
  localparam logic [BW-1:0] PRE  = BW'(CLK_DIV - 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state;
  logic [31:0]   shreg;
  logic [1:0]    byte_idx;
  logic [2:0]    bit_idx;
  logic [BW-1:0] baud_cnt;

  logic bit_end;
  logic word_end;
  logic load;

  assign bit_end  = (baud_cnt == LAST);
  assign word_end = (state == S_STOP) &&
                    (byte_idx == 2'd3) && bit_end;
  // sclr gates the pop so reset can never consume a word
  assign load = sclr & en & ~fifo_empty &
                ((state == S_IDLE) | word_end);

  assign fifo_rdreq = load;
  assign busy       = (state != S_IDLE);

  // Line level decoded from state so reset forces idle at once
  always_comb begin
    txd = 1'b1;
    unique case (state)
      S_START: txd = 1'b0;
      S_DATA:  txd = shreg[{byte_idx, bit_idx}];
      default: txd = 1'b1;
    endcase
  end

  // Frame sequencer, baud counter and end-of-word pulse
  always_ff @(posedge clock or negedge sclr) begin
    if (!sclr) begin
      state    <= S_IDLE;
      shreg    <= '0;
      byte_idx <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
      tx_done  <= 1'b0;
    end else begin
      // raised one cycle early so it lines up with the last stop cycle
      tx_done <= (state == S_STOP) &&
                 (byte_idx == 2'd3) &&
                 (baud_cnt == PRE);
      if (load) begin
        shreg    <= fifo_q;
        byte_idx <= '0;
        bit_idx  <= '0;
        baud_cnt <= '0;
        state    <= S_START;
      end else if (state != S_IDLE) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
        if (bit_end) begin
          unique case (state)
            S_START: begin
              bit_idx <= '0;
              state   <= S_DATA;
            end
            S_DATA: begin
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) state <= S_STOP;
            end
            S_STOP: begin
              if (byte_idx != 2'd3) begin
                byte_idx <= byte_idx + 2'd1;
                state    <= S_START;
              end else begin
                byte_idx <= '0;
                state    <= S_IDLE;
              end
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed vectors for fifo_uart_tx at CLK_DIV=4.
// A small array FIFO feeds the DUT; frames are captured and compared.
module tb_fifo_uart_tx;

  localparam int DIV = 4;
  localparam int WCYC = 40 * DIV;

  typedef struct {
    logic [31:0]     word;
    logic [3:0][7:0] b;
  } vec_t;

  logic        clock = 1'b0;
  logic        sclr;
  logic        en;
  logic        fifo_empty;
  logic [31:0] fifo_q;
  logic        fifo_rdreq;
  logic        txd;
  logic        busy;
  logic        tx_done;

  logic [31:0] mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_cnt = 0;

  int n_vec = 0;
  int n_bad = 0;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_q     = mem[rd_ptr % 16];

  fifo_uart_tx #(.CLK_DIV(DIV)) dut (
    .clock      (clock),
    .sclr       (sclr),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_q     (fifo_q),
    .fifo_rdreq (fifo_rdreq),
    .txd        (txd),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (fifo_rdreq) begin
      rd_ptr  <= rd_ptr + 1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic push(input logic [31:0] w);
    mem[wr_ptr % 16] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [39:0] frame_of(input logic [7:0] b);
    logic [39:0] f;
    f = '1;
    for (int i = 0; i < DIV; i++) f[i] = 1'b0;
    for (int j = 0; j < 8; j++)
      for (int r = 0; r < DIV; r++)
        f[DIV + DIV * j + r] = b[j];
    return f;
  endfunction

  task automatic wait_pop(input string nm, input int max);
    int i;
    i = 0;
    #1;
    while (!fifo_rdreq && i < max) begin
      @(negedge clock);
      #1;
      i++;
    end
    chk(nm, longint'(fifo_rdreq), 1);
  endtask

  // Called in the load cycle; walks the 160 cycles of one word.
  task automatic check_word(input string nm,
                            input vec_t v,
                            input logic exp_end_pop,
                            input int drop_en_at,
                            input int push_at,
                            input logic [31:0] push_w);
    logic [3:0][39:0] cap;
    int done_n, done_k, mid_pop, busy_lo;
    logic end_pop;
    done_n = 0; done_k = -1; mid_pop = 0;
    busy_lo = 0; end_pop = 1'b0;
    cap = '0;
    for (int k = 0; k < WCYC; k++) begin
      @(negedge clock);
      cap[k / 40][k % 40] = txd;
      if (tx_done) begin
        done_n++;
        done_k = k;
      end
      if (!busy) busy_lo++;
      if (k < WCYC - 1 && fifo_rdreq) mid_pop++;
      if (k == WCYC - 1) end_pop = fifo_rdreq;
      if (k == drop_en_at) en = 1'b0;
      if (k == push_at) push(push_w);
    end
    for (int j = 0; j < 4; j++)
      chk($sformatf("%s frame%0d", nm, j),
          longint'(cap[j]), longint'(frame_of(v.b[j])));
    chk({nm, " tx_done count"}, done_n, 1);
    chk({nm, " tx_done cycle"}, done_k, WCYC - 1);
    chk({nm, " busy low"}, busy_lo, 0);
    chk({nm, " mid pop"}, mid_pop, 0);
    chk({nm, " end pop"}, longint'(end_pop),
        longint'(exp_end_pop));
  endtask

  task automatic idle_check(input string nm, input int n);
    int pops, bad;
    pops = 0; bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (fifo_rdreq) pops++;
      if (!txd || busy || tx_done) bad++;
    end
    chk({nm, " pops"}, pops, 0);
    chk({nm, " idle line"}, bad, 0);
  endtask

  vec_t tbl [4];
  vec_t v;
  int p0;
  int bad;

  initial begin
    tbl[0] = '{32'h0000_0000, {8'h00, 8'h00, 8'h00, 8'h00}};
    tbl[1] = '{32'hFFFF_FFFF, {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    tbl[2] = '{32'h1234_5678, {8'h12, 8'h34, 8'h56, 8'h78}};
    tbl[3] = '{32'h8000_0001, {8'h80, 8'h00, 8'h00, 8'h01}};

    sclr = 1'b0;
    en   = 1'b1;
    for (int i = 0; i < 4; i++) push(tbl[i].word);

    // reset holds everything quiet despite a ready FIFO
    repeat (3) @(negedge clock);
    #1;
    chk("rst txd", longint'(txd), 1);
    chk("rst busy", longint'(busy), 0);
    chk("rst rdreq", longint'(fifo_rdreq), 0);
    chk("rst tx_done", longint'(tx_done), 0);
    chk("rst no pop", pop_cnt, 0);
    sclr = 1'b1;
    #1;
    chk("release rdreq", longint'(fifo_rdreq), 1);

    // back-to-back chain straight out of reset
    for (int i = 0; i < 4; i++)
      check_word($sformatf("chain%0d", i), tbl[i],
                 (i != 3), -1, -1, 32'h0);
    idle_check("chain tail", 20);
    chk("chain pops", pop_cnt, 4);

    // single word
    p0 = pop_cnt;
    v = '{32'hA5C3_0F81, {8'hA5, 8'hC3, 8'h0F, 8'h81}};
    push(v.word);
    wait_pop("single pop", 10);
    check_word("single", v, 1'b0, -1, -1, 32'h0);
    idle_check("single tail", 20);
    chk("single pops", pop_cnt - p0, 1);

    // word arriving in flight waits for the final stop cycle
    v = '{32'h1122_3344, {8'h11, 8'h22, 8'h33, 8'h44}};
    push(v.word);
    wait_pop("flight pop", 10);
    check_word("flight", v, 1'b1, -1, 80, 32'h0000_00C3);
    v = '{32'h0000_00C3, {8'h00, 8'h00, 8'h00, 8'hC3}};
    check_word("flight2", v, 1'b0, -1, -1, 32'h0);

    // enable gating
    en = 1'b0;
    p0 = pop_cnt;
    push(32'hDEAD_BEEF);
    push(32'h0F1E_2D3C);
    idle_check("en low", 100);
    en = 1'b1;
    wait_pop("en pop", 2);
    v = '{32'hDEAD_BEEF, {8'hDE, 8'hAD, 8'hBE, 8'hEF}};
    check_word("en drop", v, 1'b0, 20, -1, 32'h0);
    idle_check("en drop tail", 50);
    chk("en drop pops", pop_cnt - p0, 1);
    en = 1'b1;
    wait_pop("en resume pop", 2);
    v = '{32'h0F1E_2D3C, {8'h0F, 8'h1E, 8'h2D, 8'h3C}};
    check_word("en resume", v, 1'b0, -1, -1, 32'h0);

    // underflow guard
    idle_check("empty", 100);

    // asynchronous reset during byte 1 data
    p0 = pop_cnt;
    push(32'h0000_0000);
    push(32'h9E37_79B9);
    wait_pop("mid pop", 10);
    repeat (51) @(negedge clock);
    #1;
    chk("pre reset txd", longint'(txd), 0);
    sclr = 1'b0;
    #1;
    chk("async txd", longint'(txd), 1);
    chk("async busy", longint'(busy), 0);
    bad = 0;
    repeat (3) begin
      @(negedge clock);
      if (tx_done || fifo_rdreq || busy || !txd) bad++;
    end
    chk("held reset", bad, 0);
    sclr = 1'b1;
    #1;
    chk("mid release rdreq", longint'(fifo_rdreq), 1);
    v = '{32'h9E37_79B9, {8'h9E, 8'h37, 8'h79, 8'hB9}};
    check_word("after rst", v, 1'b0, -1, -1, 32'h0);
    chk("mid rst pops", pop_cnt - p0, 2);
    idle_check("final", 10);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

- Drain stage placed directly downstream of the 32-bit, 16-entry show-ahead word FIFO.
- Pops one 32-bit word at a time and serialises it as four 8N1 UART frames, least-significant byte first, each byte LSB-first.
- Reports progress to the core through a `busy` level and a per-word `tx_done` pulse.

## Interface

Parameters:
- `CLK_DIV`, default 434: clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `sclr`  in  1  reset, asynchronous, active-low.
- `en`  in  1  transmit enable; sampled only when deciding whether to pop a new word.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_q`  in  32  FIFO head word; valid whenever `fifo_empty` = 0, no read latency.
- `fifo_rdreq`  out  1  pop strobe, combinational, one cycle per word.
- `txd`  out  1  serial output; idle level 1.
- `busy`  out  1  high from the word-load edge until the last stop bit of that word completes.
- `tx_done`  out  1  one-cycle pulse on the last cycle of byte 3's stop bit.

## Operation

- **States:** IDLE, START, DATA, STOP. Registers:
  - `shreg[31:0]`
  - `byte_idx[1:0]`
  - `bit_idx[2:0]`
  - `baud_cnt` (width ceil(log2(CLK_DIV)))
- **Reset (`sclr` = 0, asynchronous):**
  - State IDLE; all counters 0; `shreg` 0.
  - `txd` = 1, `busy` = 0, `tx_done` = 0, `fifo_rdreq` = 0.
  - Takes effect immediately, mid-frame included. The partially sent word is discarded and is not re-popped. FIFO contents are untouched.
- **Load condition:** `load` = `en` & ~`fifo_empty` & (state == IDLE, or state == STOP with `byte_idx` == 3 and `baud_cnt` == CLK_DIV-1).
  - `fifo_rdreq` = `load`.
  - On that edge: `shreg` <= `fifo_q`, `byte_idx` <= 0, `baud_cnt` <= 0, state <= START.
- **Bit timing:** each bit lasts exactly CLK_DIV cycles. `baud_cnt` counts 0..CLK_DIV-1 and wraps to 0 at every bit boundary.
- **START:** `txd` = 0. At `baud_cnt` == CLK_DIV-1, go to DATA with `bit_idx` = 0.
- **DATA:** `txd` = `shreg[8*byte_idx + bit_idx]`.
  - At bit end, `bit_idx` increments.
  - After bit 7, go to STOP.
- **STOP:** `txd` = 1. At bit end:
  - if `byte_idx` < 3: `byte_idx`++, go to START (no gap between bytes of a word);
  - else if `load`: START with the new word (no gap between words);
  - else: IDLE.
- **IDLE:** `txd` = 1. Stays in IDLE while ~`en` or `fifo_empty`.
- **`en` deasserted mid-word:** the current word completes all four bytes; no further pop occurs.
- **`fifo_empty` / `en` outside the load condition:** ignored.
- **`tx_done`:** registered, asserted for exactly one cycle, coincident with the final stop-bit cycle of byte 3.
- **`busy`:** = (state != IDLE).

## Timing

- Pop-to-start latency: `fifo_rdreq` is high in cycle T; `txd` falls (start bit) from cycle T+1.
- Frame length: 10·CLK_DIV cycles per byte. A word occupies exactly 40·CLK_DIV cycles from its start-bit edge.
- Back-to-back words: the next start bit begins the cycle after the previous stop bit ends. The `fifo_rdreq` pulse lands on that last stop cycle.
- `fifo_rdreq` is never asserted while `fifo_empty` = 1, so no underflow is possible.
- `fifo_rdreq` is asserted at most once per 40·CLK_DIV cycles.
- Simultaneous FIFO write on the pop cycle: irrelevant to this block, which consumes only the head word.
- `sclr` release: first possible pop is on the first rising edge with `sclr` = 1 and the load condition true.

## Test plan

All scenarios use CLK_DIV = 4.
- **Reset values:** hold `sclr` low with `fifo_empty` = 0 and `en` = 1.
  - Require `txd` = 1, `busy` = 0, `fifo_rdreq` = 0, `tx_done` = 0.
  - After release, `fifo_rdreq` = 1 on the first edge.
- **Single word:** FIFO holds 0xA5C3_0F81, `en` = 1.
  - Exactly one `fifo_rdreq` pulse.
  - `txd` shows four frames with payloads 0x81, 0x0F, 0xC3, 0xA5, LSB first, each 40 cycles.
  - `tx_done` pulses at cycle 160 after the start edge; then IDLE with `txd` = 1.
- **Back-to-back:** FIFO holds 0x0000_0000 then 0xFFFF_FFFF.
  - Second `fifo_rdreq` occurs on the last stop cycle of word 1.
  - Word 2's start bit follows with zero idle cycles; 320 cycles total; two `tx_done` pulses 160 cycles apart.
- **Enable gating:** `en` = 0 with a non-empty FIFO leaves `fifo_rdreq` at 0 indefinitely.
  - Drop `en` mid-word: the current word finishes all 4 bytes, then IDLE with no extra pop.
- **Underflow guard:** `fifo_empty` = 1 throughout leaves `fifo_rdreq` = 0 and `txd` = 1.
  - A word written while a transmission is in flight is popped only at that word's final stop cycle.
- **Reset mid-frame:** assert `sclr` during DATA of byte 1.
  - `txd` goes to 1 asynchronously, before the next clock edge.
  - `busy` = 0 and no `tx_done`.
  - After release, the next FIFO word is transmitted from byte 0.
